// File: rtl/spi_pkg.sv
// Shared constants and types for the mode-0 SPI target: default width,
// FSM state encoding and the reset levels of the synchronized pins.
package spi_pkg;

   localparam int   WIDTH_DEF = 8;
   localparam logic SPI_CPOL  = 1'b0;
   localparam logic SPI_CPHA  = 1'b0;

   localparam logic SCK_RST_VAL = 1'b0;
   localparam logic SDI_RST_VAL = 1'b0;
   localparam logic CSX_RST_VAL = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one SPI pin, plus a registered copy of the
// synchronized value so the parent can detect rising/falling edges.
module spi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_q_prev
);

   logic [STAGES-1:0] r_chain;
   logic              r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_chain <= {STAGES{RESET_VAL}};
         r_prev  <= RESET_VAL;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
         r_prev  <= r_chain[STAGES-1];
      end
   end

   assign o_q      = r_chain[STAGES-1];
   assign o_q_prev = r_prev;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 MSB-first SPI target: oversampled pins, byte hand-off through a
// VALID/READ holding register, and a full-duplex response byte on SDO.
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = WIDTH_DEF
) (
   input  logic             CLK_100MHz,
   input  logic             RESET_N,
   input  logic             SCK,
   input  logic             SDI,
   input  logic             CSX,
   output logic             SDO,
   output logic             SDO_EN,
   output logic [WIDTH-1:0] OUT,
   output logic             VALID,
   input  logic             READ,
   output logic             OVERRUN,
   output logic             FRAME_ERR,
   input  logic [WIDTH-1:0] TX_IN,
   input  logic             TX_LOAD
);

   localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam int                ARM_N    = SYNC_STAGES + 1;
   localparam int                ARM_W    = $clog2(ARM_N + 1);
   localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_N - 1);

   logic w_sck, w_sck_prev, w_sdi, w_sdi_prev, w_csx, w_csx_prev;
   logic w_sck_rise, w_sck_fall, w_csx_rise, w_csx_fall;
   logic [WIDTH-1:0] w_tx_src;

   spi_state_t       r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;
   logic [WIDTH-1:0] r_rx, w_rx_n;
   logic [WIDTH-1:0] r_tx, w_tx_n;
   logic [WIDTH-1:0] r_hold, w_hold_n;
   logic [WIDTH-1:0] r_out, w_out_n;
   logic             r_valid, w_valid_n;
   logic             r_ovr, w_ovr_n;
   logic             r_ferr, w_ferr_n;
   logic             r_sdo, w_sdo_n;
   logic             r_sdo_en, w_sdo_en_n;
   logic             r_armed;
   logic [ARM_W-1:0] r_arm_cnt;

   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_RST_VAL)) u_sync_sck (
      .i_clk(CLK_100MHz), .i_rst_n(RESET_N), .i_d(SCK), .o_q(w_sck), .o_q_prev(w_sck_prev)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(SDI_RST_VAL)) u_sync_sdi (
      .i_clk(CLK_100MHz), .i_rst_n(RESET_N), .i_d(SDI), .o_q(w_sdi), .o_q_prev(w_sdi_prev)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CSX_RST_VAL)) u_sync_csx (
      .i_clk(CLK_100MHz), .i_rst_n(RESET_N), .i_d(CSX), .o_q(w_csx), .o_q_prev(w_csx_prev)
   );

   assign w_sck_rise = w_sck & ~w_sck_prev;
   assign w_sck_fall = ~w_sck & w_sck_prev;
   assign w_csx_rise = w_csx & ~w_csx_prev;
   assign w_csx_fall = r_armed & ~w_csx & w_csx_prev;
   assign w_tx_src   = TX_LOAD ? TX_IN : r_hold;

   // The CSX synchronizer resets high, so a select held low across reset would
   // look like a fresh fall; only arm once CSX has been high longer than the
   // reset residue can last, which discards the rest of an interrupted frame.
   always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         r_armed   <= 1'b0;
         r_arm_cnt <= '0;
      end else if (!r_armed) begin
         if (!w_csx) begin
            r_arm_cnt <= '0;
         end else if (r_arm_cnt == ARM_LAST) begin
            r_armed <= 1'b1;
         end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_rx_n     = r_rx;
      w_tx_n     = r_tx;
      w_hold_n   = w_tx_src;
      w_out_n    = r_out;
      w_valid_n  = r_valid;
      w_ovr_n    = r_ovr;
      w_ferr_n   = 1'b0;
      w_sdo_n    = r_sdo;
      w_sdo_en_n = r_sdo_en;

      if (READ) begin
         w_valid_n = 1'b0;
         w_ovr_n   = 1'b0;
      end

      case (r_state)
         IDLE: begin
            w_sdo_n    = 1'b0;
            w_sdo_en_n = 1'b0;
            if (w_csx_fall) begin
               w_state_n  = SHIFT;
               w_cnt_n    = '0;
               w_tx_n     = w_tx_src;
               w_sdo_n    = w_tx_src[WIDTH-1];
               w_sdo_en_n = 1'b1;
            end
         end
         SHIFT: begin
            if (w_sck_rise) begin
               w_rx_n = {r_rx[WIDTH-2:0], w_sdi};
               if (r_cnt == CNT_LAST) begin
                  w_cnt_n = '0;
                  if (!r_valid || READ) begin
                     w_out_n   = w_rx_n;
                     w_valid_n = 1'b1;
                  end else begin
                     w_ovr_n = 1'b1;
                  end
               end else begin
                  w_cnt_n = r_cnt + 1'b1;
               end
            end
            // A fall with the counter at zero ends a byte, so the next response starts.
            if (w_sck_fall) begin
               if (r_cnt == '0) begin
                  w_tx_n  = w_tx_src;
                  w_sdo_n = w_tx_src[WIDTH-1];
               end else begin
                  w_tx_n  = {r_tx[WIDTH-2:0], 1'b0};
                  w_sdo_n = r_tx[WIDTH-2];
               end
            end
            if (w_csx_rise) begin
               w_ferr_n   = (w_cnt_n != '0);
               w_cnt_n    = '0;
               w_state_n  = IDLE;
               w_sdo_n    = 1'b0;
               w_sdo_en_n = 1'b0;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rx     <= '0;
         r_tx     <= '0;
         r_hold   <= '0;
         r_out    <= '0;
         r_valid  <= 1'b0;
         r_ovr    <= 1'b0;
         r_ferr   <= 1'b0;
         r_sdo    <= 1'b0;
         r_sdo_en <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_rx     <= w_rx_n;
         r_tx     <= w_tx_n;
         r_hold   <= w_hold_n;
         r_out    <= w_out_n;
         r_valid  <= w_valid_n;
         r_ovr    <= w_ovr_n;
         r_ferr   <= w_ferr_n;
         r_sdo    <= w_sdo_n;
         r_sdo_en <= w_sdo_en_n;
      end
   end

   assign SDO       = r_sdo;
   assign SDO_EN    = r_sdo_en;
   assign OUT       = r_out;
   assign VALID     = r_valid;
   assign OVERRUN   = r_ovr;
   assign FRAME_ERR = r_ferr;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 controller model drives the pins,
// received bytes are checked by a scoreboard monitor on each VALID rise.
module tb_spi_slave;

   localparam int HALF = 50;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       sck = 1'b0;
   logic       sdi = 1'b0;
   logic       csx = 1'b1;
   logic       sdo, sdoEn, valid, overrun, frameErr;
   logic [7:0] outByte;
   logic       readPulse = 1'b0;
   logic [7:0] txIn = 8'h00;
   logic       txLoad = 1'b0;

   int         errorCount = 0;
   int         checkCount = 0;
   int         cycleCount = 0;
   int         lastRiseCycle = 0;
   int         frameErrCount = 0;
   logic [7:0] expQ[$];

   spi_slave dut (
      .CLK_100MHz(clk),
      .RESET_N(rstN),
      .SCK(sck),
      .SDI(sdi),
      .CSX(csx),
      .SDO(sdo),
      .SDO_EN(sdoEn),
      .OUT(outByte),
      .VALID(valid),
      .READ(readPulse),
      .OVERRUN(overrun),
      .FRAME_ERR(frameErr),
      .TX_IN(txIn),
      .TX_LOAD(txLoad)
   );

   // 100 MHz system clock and a free-running cycle counter for latency checks
   always #5 clk = ~clk;
   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode-0 controller: SDI set while SCK low, SDO sampled just before each rise
   task automatic spiBits(input logic [7:0] data, input int nBits, output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 0; i < nBits; i++) begin
         sdi = data[7-i];
         waitCycles(HALF);
         miso = {miso[6:0], sdo};
         sck = 1'b1;
         lastRiseCycle = cycleCount;
         waitCycles(HALF);
         sck = 1'b0;
      end
      waitCycles(HALF);
   endtask

   task automatic csxLow();
      csx = 1'b0;
      waitCycles(HALF);
   endtask

   task automatic csxHigh();
      csx = 1'b1;
      waitCycles(HALF);
   endtask

   task automatic pulseRead();
      readPulse = 1'b1;
      waitCycles(1);
      readPulse = 1'b0;
   endtask

   // Scoreboard monitor: each VALID rise pops one expected byte and checks latency
   initial begin
      logic validPrev;
      int   ferrRun;
      validPrev = 1'b0;
      ferrRun   = 0;
      forever begin
         @(posedge clk);
         #1;
         if (valid && !validPrev) begin
            if (expQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", outByte);
            end else begin
               checkOutput("out_byte", int'(outByte), int'(expQ.pop_front()));
               checkOutput("valid_latency", cycleCount - lastRiseCycle, 3);
            end
         end
         validPrev = valid;
         if (frameErr) begin
            ferrRun++;
         end else if (ferrRun > 0) begin
            checkOutput("frame_err_width", ferrRun, 1);
            frameErrCount++;
            ferrRun = 0;
         end
      end
   end

   task automatic applyStimulus();
      logic [7:0] miso;

      // Reset state
      waitCycles(3);
      checkOutput("rst_out", int'(outByte), 0);
      checkOutput("rst_valid", int'(valid), 0);
      checkOutput("rst_sdo_en", int'(sdoEn), 0);
      rstN = 1'b1;
      waitCycles(10);

      // Single byte, then READ clears VALID
      csxLow();
      expQ.push_back(8'hA5);
      spiBits(8'hA5, 8, miso);
      checkOutput("a5_valid", int'(valid), 1);
      pulseRead();
      checkOutput("a5_read_valid", int'(valid), 0);
      csxHigh();

      // Two bytes in one frame with READ after each
      csxLow();
      expQ.push_back(8'h3C);
      spiBits(8'h3C, 8, miso);
      pulseRead();
      expQ.push_back(8'hC3);
      spiBits(8'hC3, 8, miso);
      pulseRead();
      csxHigh();
      checkOutput("two_byte_overrun", int'(overrun), 0);
      checkOutput("two_byte_frame_err", frameErrCount, 0);

      // Overrun: second byte dropped while first is unread
      csxLow();
      expQ.push_back(8'h11);
      spiBits(8'h11, 8, miso);
      spiBits(8'h22, 8, miso);
      csxHigh();
      checkOutput("ovr_out", int'(outByte), 8'h11);
      checkOutput("ovr_valid", int'(valid), 1);
      checkOutput("ovr_flag", int'(overrun), 1);
      pulseRead();
      checkOutput("ovr_read_valid", int'(valid), 0);
      checkOutput("ovr_read_flag", int'(overrun), 0);

      // Frame error after 5 bits, then a clean frame
      csxLow();
      spiBits(8'hFF, 5, miso);
      csxHigh();
      checkOutput("ferr_count", frameErrCount, 1);
      checkOutput("ferr_valid", int'(valid), 0);
      csxLow();
      expQ.push_back(8'h5A);
      spiBits(8'h5A, 8, miso);
      pulseRead();
      csxHigh();

      // Response byte repeated across two bytes of one frame
      txIn = 8'h96;
      txLoad = 1'b1;
      waitCycles(1);
      txLoad = 1'b0;
      txIn = 8'h00;
      csxLow();
      checkOutput("tx_sdo_en", int'(sdoEn), 1);
      expQ.push_back(8'h0F);
      spiBits(8'h0F, 8, miso);
      checkOutput("tx_miso_first", int'(miso), 8'h96);
      pulseRead();
      expQ.push_back(8'h42);
      spiBits(8'h42, 8, miso);
      checkOutput("tx_miso_second", int'(miso), 8'h96);
      pulseRead();
      csxHigh();
      checkOutput("tx_idle_sdo_en", int'(sdoEn), 0);

      // Reset mid-frame; remainder of the frame must be ignored
      csxLow();
      spiBits(8'hF0, 4, miso);
      rstN = 1'b0;
      waitCycles(2);
      checkOutput("midrst_out", int'(outByte), 0);
      checkOutput("midrst_valid", int'(valid), 0);
      checkOutput("midrst_overrun", int'(overrun), 0);
      checkOutput("midrst_frame_err", int'(frameErr), 0);
      checkOutput("midrst_sdo", int'(sdo), 0);
      checkOutput("midrst_sdo_en", int'(sdoEn), 0);
      rstN = 1'b1;
      spiBits(8'h00, 4, miso);
      checkOutput("midrst_ignored_sdo_en", int'(sdoEn), 0);
      csxHigh();
      checkOutput("midrst_frame_err_count", frameErrCount, 1);
      checkOutput("midrst_valid_after", int'(valid), 0);
      csxLow();
      expQ.push_back(8'h81);
      spiBits(8'h81, 8, miso);
      pulseRead();
      csxHigh();

      checkOutput("queue_empty", expQ.size(), 0);
   endtask

   initial begin
      applyStimulus();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Bound the whole run so a stuck design cannot hang the simulation
   initial begin
      #500000;
      errorCount++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI target, the receiving end of the team's SPI controller link.
- Oversamples the external SCK/SDI/CSX in the CLK_100MHz domain and delivers each received byte through a VALID/READ holding register.
- Shifts a host-loaded response byte out on SDO, full-duplex.
- Sits between the board SPI pins and the host/CPU bus logic.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for SCK/SDI/CSX; minimum 2.
- WIDTH, 8, bits per transfer.

Ports:
- CLK_100MHz  in  1  system clock.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- SCK  in  1  SPI clock from the external controller.
- SDI  in  1  serial data in (controller to target).
- CSX  in  1  chip select, active LOW.
- SDO  out  1  serial data out (target to controller).
- SDO_EN  out  1  high while the target is selected; drives the pad tri-state enable.
- OUT  out  WIDTH  last received byte.
- VALID  out  1  OUT holds an unread byte.
- READ  in  1  one-cycle pulse; consumes OUT.
- OVERRUN  out  1  sticky; a byte was dropped because VALID was still high.
- FRAME_ERR  out  1  one-cycle pulse; CSX deasserted mid-byte.
- TX_IN  in  WIDTH  response byte.
- TX_LOAD  in  1  latches TX_IN into the TX holding register.

Behaviour:
- Reset: RESET_N low asynchronously clears OUT=0, VALID=0, OVERRUN=0, FRAME_ERR=0, SDO=0, SDO_EN=0, TX holding register=0, bit counter=0, state=IDLE.
- Reset mid-frame: partial byte discarded. After release, the FSM waits for a CSX falling edge, so the rest of an in-flight frame is ignored.
- Reset values of synchronizer flops: SCK=0, SDI=0, CSX=1.
- Edge detection: each synchronized signal is compared with its previous value. The design functions only if the SCK half-period is at least SYNC_STAGES+2 CLK cycles; at the default 1 MHz SPI rate this is 50 cycles.
- FSM IDLE:
  - SDO_EN=0, SDO=0.
  - On a synced CSX fall: go to SHIFT, clear the bit counter, copy the TX holding register into the TX shift register, SDO_EN=1.
  - SDO is driven with TX[WIDTH-1] in the same cycle.
- FSM SHIFT:
  - Synced SCK rise: RX shift register <= {rx[WIDTH-2:0], SDI_sync}; bit counter increments.
  - Synced SCK fall: TX shift register shifts left and SDO <= next bit.
  - After the WIDTH-th fall, the TX shift register reloads from the TX holding register for the next byte.
  - Byte completion is the WIDTH-th rise:
    - If VALID=0 or READ=1 in that cycle: OUT <= assembled byte, VALID=1.
    - Otherwise: byte dropped, OVERRUN=1, OUT unchanged.
    - The bit counter wraps to 0 and the FSM stays in SHIFT, so multi-byte frames are supported.
- Synced CSX rise in SHIFT:
  - If the bit counter is not 0: FRAME_ERR=1 for exactly one cycle and the partial byte is discarded.
  - Always: go to IDLE, SDO_EN=0, SDO=0.
  - A CSX rise coinciding with an SCK rise is processed as SCK first, then CSX.
- Latency: VALID rises SYNC_STAGES+1 CLK cycles after the pin-level WIDTH-th SCK rise (3 cycles at default).
- READ:
  - Clears VALID and OVERRUN on the next clock edge.
  - READ while VALID=0 is ignored, and OVERRUN is cleared.
  - READ coinciding with byte completion stores the new byte, keeps VALID=1, and does not set OVERRUN.
- TX_LOAD:
  - Updates only the holding register; it never disturbs a byte in flight.
  - If TX_LOAD is asserted in the same cycle as a reload, the new TX_IN value is the one loaded.
  - The holding register keeps its value after use; the same byte is repeated until it is reloaded.
- SCK edges while IDLE are ignored.

Decomposition:
- spi_pkg: WIDTH default, mode-0 constants, FSM state encoding (IDLE=1'b0, SHIFT=1'b1), reset levels of synced pins.
- Sub-module spi_sync: SYNC_STAGES-deep synchronizer with a parameterized reset value, plus a registered previous-value output for edge detection. Instantiated three times.

Test Plan:
- Mode-0 controller model at 50-cycle half-period sends 0xA5 → OUT=0xA5, VALID=1 three cycles after the 8th SCK rise. Then READ → VALID=0 next cycle.
- Single CSX frame carrying 0x3C then 0xC3, with READ pulsed after each → OUT sequence 0x3C, 0xC3; OVERRUN=0, FRAME_ERR never asserted.
- Send 0x11 then 0x22 with no READ → OUT=0x11, VALID=1, OVERRUN=1. Then READ → VALID=0, OVERRUN=0.
- CSX raised after 5 bits of 0xFF → FRAME_ERR single-cycle pulse, VALID stays 0. Next frame 0x5A → OUT=0x5A.
- TX_IN=0x96 with TX_LOAD before CSX falls; controller samples SDO on SCK rises → receives 0x96 while the target receives 0x0F. A second byte in the same frame returns 0x96 again.
- RESET_N low for 2 cycles after 4 bits of 0xF0 → all outputs at reset values. Remainder of that frame ignored. Next full frame 0x81 → OUT=0x81.
